// File: rtl/fetch_pkg.sv
// fetch_pkg: shared FSM state type and default parameters for the fetch unit.
package fetch_pkg;
  typedef enum logic [1:0] {ISSUE, WAIT, KILL} state_t;
  localparam int DEF_XLEN = 32;
  localparam logic [63:0] DEF_RESET_PC = '0;
  localparam int DEF_PC_STEP = 4;
  localparam int DEF_BUF_DEPTH = 4;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: synchronous FIFO of fetched entries with flush and occupancy count.
module fetch_buffer #(
  parameter int W = 96,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= wdata;
  end
  assign rdata = mem[rp];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetcher feeding decode through a small buffer.
module fetch_unit import fetch_pkg::*; #(
  parameter int              XLEN      = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(DEF_RESET_PC),
  parameter int              PC_STEP   = DEF_PC_STEP,
  parameter int              BUF_DEPTH = DEF_BUF_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            d_valid,
  input  logic            d_ready,
  output logic [31:0]     d_instr,
  output logic [XLEN-1:0] d_pc,
  output logic [XLEN-1:0] d_pcplus
);
  localparam int W = 32 + 2*XLEN;
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);
  localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);
  state_t state, state_nx;
  logic [XLEN-1:0] fetch_pc, pc_next;
  logic [CW-1:0] count;
  logic [W-1:0] head;
  logic push, pop;
  assign pc_next = fetch_pc + STEP;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ISSUE;
      fetch_pc <= RESET_PC;
    end else begin
      state <= state_nx;
      fetch_pc <= redirect_valid ? redirect_pc : (push ? pc_next : fetch_pc);
    end
  end
  // A response arriving while killed or alongside a redirect is dropped by returning to ISSUE.
  always_comb begin
    state_nx = (state == ISSUE) ? (imem_req ? WAIT : ISSUE)
             : imem_rvalid ? ISSUE
             : (state == WAIT && !redirect_valid) ? WAIT : KILL;
  end
  always_comb begin
    imem_req = rst && state == ISSUE && count != FULL && !redirect_valid;
    imem_addr = fetch_pc;
    push = state == WAIT && imem_rvalid && !redirect_valid;
    d_valid = rst && count != '0;
    pop = d_valid && d_ready && !redirect_valid;
    {d_instr, d_pc, d_pcplus} = d_valid ? head : '0;
  end
  fetch_buffer #(.W(W), .DEPTH(BUF_DEPTH)) u_buf (
    .clk(clk),
    .rst(rst),
    .flush(redirect_valid),
    .push(push),
    .pop(pop),
    .wdata({imem_rdata, fetch_pc, pc_next}),
    .rdata(head),
    .count(count)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios for fetch_unit with a latency-configurable memory model.
module tb_fetch_unit;
  logic clk, rst, redirect_valid, d_ready;
  logic [31:0] redirect_pc;
  logic imem_req, imem_rvalid, d_valid;
  logic [31:0] imem_addr, imem_rdata, d_instr, d_pc, d_pcplus;
  logic req2, rvalid2, d_valid2;
  logic [31:0] addr2, d_instr2, d_pc2, d_pcplus2;
  int vectors = 0, miscompares = 0;
  int lat = 1, cnt;
  logic pend;
  logic [31:0] la;

  fetch_unit dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .d_valid(d_valid), .d_ready(d_ready), .d_instr(d_instr), .d_pc(d_pc), .d_pcplus(d_pcplus)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst), .redirect_valid(1'b0), .redirect_pc(32'h0),
    .imem_req(req2), .imem_addr(addr2), .imem_rvalid(rvalid2), .imem_rdata(32'h0000_0013),
    .d_valid(d_valid2), .d_ready(1'b0), .d_instr(d_instr2), .d_pc(d_pc2), .d_pcplus(d_pcplus2)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1300_0013;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      imem_rvalid <= 0;
      imem_rdata <= 0;
      pend <= 0;
      cnt <= 0;
      la <= 0;
    end else begin
      imem_rvalid <= 0;
      if (pend) begin
        if (cnt <= 1) begin
          imem_rvalid <= 1;
          imem_rdata <= instr_of(la);
          pend <= 0;
        end else cnt <= cnt - 1;
      end
      if (imem_req) begin
        la <= imem_addr;
        if (lat == 1) begin
          imem_rvalid <= 1;
          imem_rdata <= instr_of(imem_addr);
        end else begin
          pend <= 1;
          cnt <= lat - 1;
        end
      end
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) rvalid2 <= 0;
    else rvalid2 <= req2;
  end

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    rst = 0;
    redirect_valid = 0;
    redirect_pc = 0;
    d_ready = rdy;
    step;
    step;
    rst = 1;
    #1;
  endtask

  task automatic test_reset;
    rst = 0;
    redirect_valid = 0;
    redirect_pc = 0;
    d_ready = 1;
    step;
    step;
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req got %b exp 0", imem_req); end
    vectors++; if (d_valid !== 1'b0) begin miscompares++; $display("FAIL reset_dvalid got %b exp 0", d_valid); end
    vectors++; if (d_pc !== 32'h0) begin miscompares++; $display("FAIL reset_dpc got %h exp 0", d_pc); end
    vectors++; if (d_pcplus !== 32'h0) begin miscompares++; $display("FAIL reset_dpcplus got %h exp 0", d_pcplus); end
    vectors++; if (d_instr !== 32'h0) begin miscompares++; $display("FAIL reset_dinstr got %h exp 0", d_instr); end
    vectors++; if (req2 !== 1'b0) begin miscompares++; $display("FAIL reset_req2 got %b exp 0", req2); end
    rst = 1;
    #1;
    vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL release_req got %b exp 1", imem_req); end
    vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL release_addr got %h exp 0", imem_addr); end
    vectors++; if (addr2 !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL release_addr2 got %h exp fffffffc", addr2); end
  endtask

  task automatic test_stream;
    lat = 1;
    do_reset(1);
    for (int k = 0; k < 3; k++) begin
      vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL stream_req[%0d] got %b exp 1", k, imem_req); end
      vectors++; if (imem_addr !== 32'(4*k)) begin miscompares++; $display("FAIL stream_addr[%0d] got %h exp %h", k, imem_addr, 32'(4*k)); end
      if (k == 0) begin
        vectors++; if (d_valid !== 1'b0) begin miscompares++; $display("FAIL stream_dvalid0 got %b exp 0", d_valid); end
      end else begin
        vectors++; if (d_valid !== 1'b1) begin miscompares++; $display("FAIL stream_dvalid[%0d] got %b exp 1", k, d_valid); end
        vectors++; if (d_pc !== 32'(4*(k-1))) begin miscompares++; $display("FAIL stream_dpc[%0d] got %h exp %h", k, d_pc, 32'(4*(k-1))); end
        vectors++; if (d_pcplus !== 32'(4*k)) begin miscompares++; $display("FAIL stream_dpcplus[%0d] got %h exp %h", k, d_pcplus, 32'(4*k)); end
        vectors++; if (d_instr !== instr_of(32'(4*(k-1)))) begin miscompares++; $display("FAIL stream_dinstr[%0d] got %h exp %h", k, d_instr, instr_of(32'(4*(k-1)))); end
      end
      step;
      vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL stream_wait_req[%0d] got %b exp 0", k, imem_req); end
      step;
    end
  endtask

  task automatic test_stall;
    lat = 1;
    do_reset(0);
    repeat (12) step;
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL stall_req got %b exp 0", imem_req); end
    vectors++; if (d_valid !== 1'b1) begin miscompares++; $display("FAIL stall_dvalid got %b exp 1", d_valid); end
    vectors++; if (d_pc !== 32'h0) begin miscompares++; $display("FAIL stall_dpc got %h exp 0", d_pc); end
    vectors++; if (d_instr !== instr_of(32'h0)) begin miscompares++; $display("FAIL stall_dinstr got %h exp %h", d_instr, instr_of(32'h0)); end
    step;
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL stall_req_hold got %b exp 0", imem_req); end
    d_ready = 1;
    step;
    d_ready = 0;
    #1;
    vectors++; if (d_pc !== 32'h4) begin miscompares++; $display("FAIL stall_pop_dpc got %h exp 4", d_pc); end
    vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL stall_resume_req got %b exp 1", imem_req); end
    vectors++; if (imem_addr !== 32'h10) begin miscompares++; $display("FAIL stall_resume_addr got %h exp 10", imem_addr); end
  endtask

  task automatic test_redirect_wait;
    lat = 2;
    do_reset(0);
    step;
    redirect_valid = 1;
    redirect_pc = 32'h100;
    #1;
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rdw_req_wait got %b exp 0", imem_req); end
    step;
    redirect_valid = 0;
    #1;
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rdw_req_kill got %b exp 0", imem_req); end
    vectors++; if (d_valid !== 1'b0) begin miscompares++; $display("FAIL rdw_dvalid_kill got %b exp 0", d_valid); end
    step;
    vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL rdw_req got %b exp 1", imem_req); end
    vectors++; if (imem_addr !== 32'h100) begin miscompares++; $display("FAIL rdw_addr got %h exp 100", imem_addr); end
    vectors++; if (d_valid !== 1'b0) begin miscompares++; $display("FAIL rdw_discard got %b exp 0", d_valid); end
    repeat (3) step;
    vectors++; if (d_valid !== 1'b1) begin miscompares++; $display("FAIL rdw_dvalid got %b exp 1", d_valid); end
    vectors++; if (d_pc !== 32'h100) begin miscompares++; $display("FAIL rdw_dpc got %h exp 100", d_pc); end
    vectors++; if (d_instr !== instr_of(32'h100)) begin miscompares++; $display("FAIL rdw_dinstr got %h exp %h", d_instr, instr_of(32'h100)); end
  endtask

  task automatic test_redirect_rvalid;
    lat = 1;
    do_reset(0);
    repeat (5) step;
    vectors++; if (d_valid !== 1'b1) begin miscompares++; $display("FAIL rdr_pre_dvalid got %b exp 1", d_valid); end
    vectors++; if (d_pc !== 32'h0) begin miscompares++; $display("FAIL rdr_pre_dpc got %h exp 0", d_pc); end
    redirect_valid = 1;
    redirect_pc = 32'h200;
    d_ready = 1;
    #1;
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rdr_req_redirect got %b exp 0", imem_req); end
    step;
    redirect_valid = 0;
    d_ready = 0;
    #1;
    vectors++; if (d_valid !== 1'b0) begin miscompares++; $display("FAIL rdr_flush got %b exp 0", d_valid); end
    vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL rdr_req got %b exp 1", imem_req); end
    vectors++; if (imem_addr !== 32'h200) begin miscompares++; $display("FAIL rdr_addr got %h exp 200", imem_addr); end
    step;
    step;
    vectors++; if (d_valid !== 1'b1) begin miscompares++; $display("FAIL rdr_dvalid got %b exp 1", d_valid); end
    vectors++; if (d_pc !== 32'h200) begin miscompares++; $display("FAIL rdr_dpc got %h exp 200", d_pc); end
    vectors++; if (d_pcplus !== 32'h204) begin miscompares++; $display("FAIL rdr_dpcplus got %h exp 204", d_pcplus); end
  endtask

  task automatic test_wrap;
    do_reset(0);
    step;
    step;
    vectors++; if (d_valid2 !== 1'b1) begin miscompares++; $display("FAIL wrap_dvalid got %b exp 1", d_valid2); end
    vectors++; if (d_pc2 !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_dpc got %h exp fffffffc", d_pc2); end
    vectors++; if (d_pcplus2 !== 32'h0) begin miscompares++; $display("FAIL wrap_dpcplus got %h exp 0", d_pcplus2); end
    vectors++; if (d_instr2 !== 32'h13) begin miscompares++; $display("FAIL wrap_dinstr got %h exp 13", d_instr2); end
    vectors++; if (req2 !== 1'b1) begin miscompares++; $display("FAIL wrap_req got %b exp 1", req2); end
    vectors++; if (addr2 !== 32'h0) begin miscompares++; $display("FAIL wrap_addr got %h exp 0", addr2); end
  endtask

  task automatic test_reset_mid;
    lat = 1;
    do_reset(0);
    repeat (7) step;
    vectors++; if (d_valid !== 1'b1) begin miscompares++; $display("FAIL mid_pre_dvalid got %b exp 1", d_valid); end
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL mid_pre_req got %b exp 0", imem_req); end
    vectors++; if (imem_addr !== 32'hC) begin miscompares++; $display("FAIL mid_pre_addr got %h exp c", imem_addr); end
    rst = 0;
    #1;
    vectors++; if (d_valid !== 1'b0) begin miscompares++; $display("FAIL mid_dvalid got %b exp 0", d_valid); end
    vectors++; if (d_pc !== 32'h0) begin miscompares++; $display("FAIL mid_dpc got %h exp 0", d_pc); end
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL mid_req got %b exp 0", imem_req); end
    step;
    rst = 1;
    #1;
    vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL mid_release_req got %b exp 1", imem_req); end
    vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL mid_release_addr got %h exp 0", imem_addr); end
    vectors++; if (d_valid !== 1'b0) begin miscompares++; $display("FAIL mid_release_dvalid got %b exp 0", d_valid); end
  endtask

  initial begin
    test_reset;
    test_stream;
    test_stall;
    test_redirect_wait;
    test_redirect_rvalid;
    test_wrap;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
